// File: rtl/display_mux_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// scan phase encoding, the blank code and the hex glyph table.
package display_mux_ctrl_pkg;

  // All segments off (active-low cathodes {g,f,e,d,c,b,a}).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // PH_GAP marks the single cycle after a step, during which all anodes
  // are held off before the next digit is driven.
  typedef enum logic {
    PH_HOLD = 1'b0,
    PH_GAP  = 1'b1
  } phase_t;

  // Standard hex glyphs, active-low, g in the MSB.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/display_mux_ctrl_hex_to_7seg.sv
// Purely combinational nibble to active-low 7-segment glyph decoder.
module hex_to_7seg
  import display_mux_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg = hex_glyph(nibble);
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexed 8-digit 7-segment display controller. Steps one digit
// per rising edge of the divided pix_clk level, inserts a one-cycle anode
// blanking gap after each step, and latches a coherent frame at each wrap.
module display_mux_ctrl
  import display_mux_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  pix_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic                pix_d1;
  logic                armed;
  logic                step;
  logic                wrap;
  logic [IDX_W-1:0]    idx;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic [DIGITS-1:0]   suppress;
  logic [3:0]          nibble;
  logic [6:0]          glyph;
  logic [6:0]          digit_seg;
  logic                digit_dp_n;

  phase_t              phase;
  phase_t              phase_nxt;
  logic [DIGITS-1:0]   anode_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_n_nxt;
  logic                frame_done_nxt;

  // Sample the divided clock level; armed blocks a false edge when pix_clk
  // is already high on the first cycle out of reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      pix_d1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      pix_d1 <= pix_clk;
      armed  <= 1'b1;
    end
  end

  // One-cycle step on each rising edge of pix_clk; wrap marks the 7 -> 0 step.
  always_comb begin
    step = pix_clk & ~pix_d1 & armed;
    wrap = step && (idx == IDX_LAST);
  end

  // Digit index and frame shadows; shadows only change at the wrap so a
  // whole scan shows one frame.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      idx      <= '0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= 1'b0;
    end else if (step) begin
      if (wrap) begin
        idx      <= '0;
        sh_data  <= data;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        sh_lz    <= lz_en;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Leading-zero mask: walking down from the top digit, suppression stops at
  // the first nonzero nibble or lit decimal point; digit 0 is always shown.
  always_comb begin
    logic        keep;
    int unsigned pos;
    keep     = 1'b0;
    pos      = 0;
    suppress = '0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      pos         = DIGITS - 1 - k;
      keep        = keep | (sh_data[4*pos +: 4] != 4'h0) | sh_dp[pos];
      suppress[pos] = sh_lz & ~keep;
    end
  end

  // Select the nibble of the current digit from the frame shadow.
  always_comb begin
    nibble = sh_data[4*idx +: 4];
  end

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Per-digit segment/dp after force-blank and leading-zero suppression.
  always_comb begin
    if (sh_blank[idx] || suppress[idx]) begin
      digit_seg  = SEG_BLANK;
      digit_dp_n = 1'b1;
    end else begin
      digit_seg  = glyph;
      digit_dp_n = ~sh_dp[idx];
    end
  end

  // Scan phase register.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      phase <= PH_HOLD;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Next phase and next output values: blank on a step, drive the new digit
  // in the following cycle, otherwise hold.
  always_comb begin
    phase_nxt      = step ? PH_GAP : PH_HOLD;
    anode_nxt      = anode;
    seg_nxt        = seg;
    dp_n_nxt       = dp_n;
    frame_done_nxt = 1'b0;
    if (step) begin
      anode_nxt      = '1;
      seg_nxt        = SEG_BLANK;
      dp_n_nxt       = 1'b1;
      frame_done_nxt = wrap;
    end else if (phase == PH_GAP) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        anode_nxt[k] = (IDX_W'(k) != idx);
      end
      seg_nxt  = digit_seg;
      dp_n_nxt = digit_dp_n;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      anode      <= '1;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      dp_n       <= dp_n_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed self-checking bench for display_mux_ctrl.
module tb_display_mux_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        pix_clk;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        lz_en;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cur_idx = 0;
  int bad_cycles;

  display_mux_ctrl #(.DIGITS(8)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .pix_clk    (pix_clk),
    .data       (data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .anode      (anode),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pix_clk rising edge: gap cycle, then the next digit, then held.
  task automatic step_chk(input logic [6:0] es, input logic edp, input logic efd);
    logic [7:0] ea;
    cur_idx = (cur_idx + 1) % 8;
    ea = ~(8'h01 << cur_idx);
    pix_clk = 1'b1;
    tick();
    chk($sformatf("gap_anode_d%0d", cur_idx), 32'(anode), 32'hFF);
    chk($sformatf("gap_frame_done_d%0d", cur_idx), 32'(frame_done), 32'(efd));
    tick();
    chk($sformatf("anode_d%0d", cur_idx), 32'(anode), 32'(ea));
    chk($sformatf("seg_d%0d", cur_idx), 32'(seg), 32'(es));
    chk($sformatf("dp_n_d%0d", cur_idx), 32'(dp_n), 32'(edp));
    chk($sformatf("frame_done_low_d%0d", cur_idx), 32'(frame_done), 32'h0);
    pix_clk = 1'b0;
    tick();
    chk($sformatf("hold_seg_d%0d", cur_idx), 32'(seg), 32'(es));
    chk($sformatf("hold_anode_d%0d", cur_idx), 32'(anode), 32'(ea));
  endtask

  initial begin
    reset    = 1'b0;
    pix_clk  = 1'b0;
    data     = 32'h0;
    dp_in    = 8'h00;
    blank_in = 8'h00;
    lz_en    = 1'b0;

    // Reset held with pix_clk toggling.
    for (int i = 0; i < 3; i++) begin
      pix_clk = ~pix_clk;
      tick();
      chk("rst_anode", 32'(anode), 32'hFF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp_n", 32'(dp_n), 32'h1);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
    end

    // Release with pix_clk already high: not an edge.
    pix_clk = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    chk("release_no_edge_anode", 32'(anode), 32'hFF);
    pix_clk = 1'b0;
    tick();

    // First scan shows the reset (all-zero) shadow; wrap loads the new frame.
    data = 32'h89AB_CDEF;
    repeat (7) step_chk(7'h40, 1'b1, 1'b0);
    step_chk(7'h0E, 1'b1, 1'b1);
    step_chk(7'h06, 1'b1, 1'b0);
    step_chk(7'h21, 1'b1, 1'b0);
    step_chk(7'h46, 1'b1, 1'b0);
    step_chk(7'h03, 1'b1, 1'b0);
    step_chk(7'h08, 1'b1, 1'b0);
    step_chk(7'h10, 1'b1, 1'b0);
    step_chk(7'h00, 1'b1, 1'b0);

    // Leading-zero suppression.
    data  = 32'h0000_0105;
    lz_en = 1'b1;
    step_chk(7'h12, 1'b1, 1'b1);
    step_chk(7'h40, 1'b1, 1'b0);
    step_chk(7'h79, 1'b1, 1'b0);
    repeat (5) step_chk(7'h7F, 1'b1, 1'b0);

    // Decimal point on digit 4 stops suppression at digits 4 and 3.
    dp_in = 8'h10;
    step_chk(7'h12, 1'b1, 1'b1);
    step_chk(7'h40, 1'b1, 1'b0);
    step_chk(7'h79, 1'b1, 1'b0);
    step_chk(7'h40, 1'b1, 1'b0);
    step_chk(7'h40, 1'b0, 1'b0);
    repeat (3) step_chk(7'h7F, 1'b1, 1'b0);

    // Coherency: data changes mid-scan after digit 3.
    data  = 32'h1111_1111;
    lz_en = 1'b0;
    dp_in = 8'h00;
    step_chk(7'h79, 1'b1, 1'b1);
    repeat (3) step_chk(7'h79, 1'b1, 1'b0);
    data = 32'h2222_2222;
    repeat (4) step_chk(7'h79, 1'b1, 1'b0);
    step_chk(7'h24, 1'b1, 1'b1);
    repeat (7) step_chk(7'h24, 1'b1, 1'b0);

    // Force-blank overrides the decimal point.
    blank_in = 8'h81;
    dp_in    = 8'h01;
    step_chk(7'h7F, 1'b1, 1'b1);
    repeat (6) step_chk(7'h24, 1'b1, 1'b0);
    step_chk(7'h7F, 1'b1, 1'b0);

    // pix_clk rises once then stays high: one step, then static outputs.
    pix_clk = 1'b1;
    tick();
    chk("static_gap_anode", 32'(anode), 32'hFF);
    chk("static_gap_frame_done", 32'(frame_done), 32'h1);
    tick();
    chk("static_anode", 32'(anode), 32'hFE);
    chk("static_seg", 32'(seg), 32'h7F);
    cur_idx = 0;
    bad_cycles = 0;
    repeat (1000) begin
      tick();
      if (anode !== 8'hFE || seg !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0)
        bad_cycles++;
    end
    chk("static_changed_cycles", 32'(bad_cycles), 32'h0);
    pix_clk = 1'b0;
    tick();

    // Reset mid-scan clears index and shadows.
    step_chk(7'h24, 1'b1, 1'b0);
    step_chk(7'h24, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    chk("midrst_anode", 32'(anode), 32'hFF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp_n", 32'(dp_n), 32'h1);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b1;
    tick();
    cur_idx = 0;
    step_chk(7'h40, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
